// File: rtl/led_ctrl_pkg.sv
// Shared LED controller types: mode encodings, controller states and counter width helper.
package led_ctrl_pkg;

  typedef enum logic [1:0] {
    MODE_OFF     = 2'd0,
    MODE_ON      = 2'd1,
    MODE_BLINK   = 2'd2,
    MODE_BREATHE = 2'd3
  } mode_t;

  // Encodings driven by the board control logic on cmd_mode
  localparam logic [1:0] LED_CMD_OFF     = 2'd0;
  localparam logic [1:0] LED_CMD_ON      = 2'd1;
  localparam logic [1:0] LED_CMD_BLINK   = 2'd2;
  localparam logic [1:0] LED_CMD_BREATHE = 2'd3;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_PEND = 2'd1;
  localparam logic [1:0] ST_FADE = 2'd2;

  // Bits needed to hold values 0..max_val, never less than one
  function automatic int unsigned cnt_width(input int unsigned max_val);
    int unsigned w;
    w = $clog2(max_val + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/led_mode_ctrl_pwm_gen.sv
// PWM period counter with terminal-count tick and duty compare; shared by all LED channels.
module pwm_gen
  import led_ctrl_pkg::*;
#(
  parameter int unsigned PERIOD = 50000,
  parameter int unsigned DUTY_W = 13
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DUTY_W-1:0] i_duty,
  output logic              o_tick,
  output logic              o_led
);

  localparam int unsigned CNT_W = cnt_width(PERIOD);
  localparam int unsigned CMP_W = (CNT_W > DUTY_W) ? CNT_W : DUTY_W;

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (o_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_tick = (r_cnt == CNT_W'(PERIOD));
  assign o_led  = (CMP_W'(r_cnt) < CMP_W'(i_duty));

endmodule

// File: rtl/led_mode_ctrl.sv
// LED mode controller: command handshake, period-aligned mode apply and duty sequencing.
// Build option FADE_OUT_EN: fade duty to zero before switching to a different mode.
module led_mode_ctrl
  import led_ctrl_pkg::*;
#(
  parameter int unsigned PERIOD        = 50000,
  parameter int unsigned MAX_DUTY      = 5000,
  parameter int unsigned STEP          = 25,
  parameter int unsigned BLINK_PERIODS = 100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  input  logic [1:0] cmd_mode,
  output logic       cmd_ready,
  output logic       busy,
  output logic [1:0] mode_o,
  output logic       tick,
  output logic       led
);

  localparam int unsigned DUTY_W = cnt_width(MAX_DUTY);
  localparam int unsigned BLK_W  = cnt_width(BLINK_PERIODS - 1);
  localparam logic [DUTY_W-1:0] DUTY_FULL = DUTY_W'(MAX_DUTY);
  localparam logic [DUTY_W-1:0] DUTY_STEP = DUTY_W'(STEP);
  localparam logic [BLK_W-1:0]  BLK_LAST  = BLK_W'(BLINK_PERIODS - 1);

  logic [1:0]        r_state,     w_state_nxt;
  mode_t             r_mode,      w_mode_nxt;
  mode_t             r_pend_mode, w_pend_nxt;
  logic [DUTY_W-1:0] r_duty,      w_duty_nxt;
  logic              r_dir_down,  w_dir_nxt;
  logic [BLK_W-1:0]  r_blink_cnt, w_blink_nxt;

  logic              w_tick;
  logic              w_accept;
  logic              w_apply;
  logic [DUTY_W:0]   w_sum;
  logic [DUTY_W-1:0] w_duty_up;
  logic [DUTY_W-1:0] w_duty_dn;

  pwm_gen #(
    .PERIOD (PERIOD),
    .DUTY_W (DUTY_W)
  ) u_pwm (
    .clk    (clk),
    .rst    (rst),
    .i_duty (r_duty),
    .o_tick (w_tick),
    .o_led  (led)
  );

  assign busy      = (r_state != ST_IDLE);
  assign cmd_ready = ~busy;
  assign mode_o    = r_mode;
  assign tick      = w_tick;
  assign w_accept  = cmd_valid && cmd_ready;

  // Saturating duty step in both directions
  assign w_sum     = {1'b0, r_duty} + {1'b0, DUTY_STEP};
  assign w_duty_up = (w_sum >= {1'b0, DUTY_FULL}) ? DUTY_FULL : w_sum[DUTY_W-1:0];
  assign w_duty_dn = (r_duty <= DUTY_STEP) ? '0 : (r_duty - DUTY_STEP);

  always_comb begin
    w_state_nxt = r_state;
    w_mode_nxt  = r_mode;
    w_pend_nxt  = r_pend_mode;
    w_duty_nxt  = r_duty;
    w_dir_nxt   = r_dir_down;
    w_blink_nxt = r_blink_cnt;
    w_apply     = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_nxt = ST_PEND;
          w_pend_nxt  = mode_t'(cmd_mode);
        end
      end
      ST_PEND: begin
        if (w_tick) begin
`ifdef FADE_OUT_EN
          if ((r_pend_mode != r_mode) && (r_duty != '0)) begin
            w_state_nxt = ST_FADE;
            w_duty_nxt  = w_duty_dn;
          end else begin
            w_apply = 1'b1;
          end
`else
          w_apply = 1'b1;
`endif
        end
      end
`ifdef FADE_OUT_EN
      ST_FADE: begin
        if (w_tick) begin
          if (r_duty == '0) begin
            w_apply = 1'b1;
          end else begin
            w_duty_nxt = w_duty_dn;
          end
        end
      end
`endif
      default: w_state_nxt = ST_IDLE;
    endcase

    if (w_apply) begin
      w_state_nxt = ST_IDLE;
      w_mode_nxt  = r_pend_mode;
      case (r_pend_mode)
        MODE_OFF:     w_duty_nxt = '0;
        MODE_ON:      w_duty_nxt = DUTY_FULL;
        MODE_BLINK: begin
          w_duty_nxt  = DUTY_FULL;
          w_blink_nxt = '0;
        end
        MODE_BREATHE: begin
          w_duty_nxt = '0;
          w_dir_nxt  = 1'b0;
        end
        default:      w_duty_nxt = '0;
      endcase
    end else if (w_tick && (r_state == ST_IDLE)) begin
      // Pattern advances once per period while no mode change is in flight
      case (r_mode)
        MODE_BLINK: begin
          if (r_blink_cnt == BLK_LAST) begin
            w_blink_nxt = '0;
            w_duty_nxt  = (r_duty == '0) ? DUTY_FULL : '0;
          end else begin
            w_blink_nxt = r_blink_cnt + BLK_W'(1);
          end
        end
        MODE_BREATHE: begin
          if (!r_dir_down) begin
            if (r_duty == DUTY_FULL) w_dir_nxt  = 1'b1;
            else                     w_duty_nxt = w_duty_up;
          end else begin
            if (r_duty == '0)        w_dir_nxt  = 1'b0;
            else                     w_duty_nxt = w_duty_dn;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_mode      <= MODE_OFF;
      r_pend_mode <= MODE_OFF;
      r_duty      <= '0;
      r_dir_down  <= 1'b0;
      r_blink_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_mode      <= w_mode_nxt;
      r_pend_mode <= w_pend_nxt;
      r_duty      <= w_duty_nxt;
      r_dir_down  <= w_dir_nxt;
      r_blink_cnt <= w_blink_nxt;
    end
  end

endmodule

// File: tb/tb_led_mode_ctrl.sv
// Self-checking bench for led_mode_ctrl; directed scenarios then random commands against a reference model.
module tb_led_mode_ctrl;

  localparam int P    = 19;
  localparam int MAXD = 20;
  localparam int STP  = 5;
  localparam int BP   = 2;
  localparam int LEN  = P + 1;
`ifdef FADE_OUT_EN
  localparam bit FADE = 1'b1;
`else
  localparam bit FADE = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic [1:0] cmd_mode;
  logic       cmd_ready;
  logic       busy;
  logic [1:0] mode_o;
  logic       tick;
  logic       led;

  int checks = 0;
  int errors = 0;

  // Reference model: position in period, applied/pending mode, duty and pattern phase
  int m_cnt, m_mode, m_pend, m_duty, m_blink;
  bit m_pending, m_fading, m_up;

  led_mode_ctrl #(
    .PERIOD        (P),
    .MAX_DUTY      (MAXD),
    .STEP          (STP),
    .BLINK_PERIODS (BP)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_mode  (cmd_mode),
    .cmd_ready (cmd_ready),
    .busy      (busy),
    .mode_o    (mode_o),
    .tick      (tick),
    .led       (led)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_mode = 0; m_pend = 0; m_duty = 0; m_blink = 0;
    m_pending = 1'b0; m_fading = 1'b0; m_up = 1'b1;
  endtask

  task automatic model_apply();
    m_mode    = m_pend;
    m_pending = 1'b0;
    m_fading  = 1'b0;
    m_duty    = (m_pend == 1 || m_pend == 2) ? MAXD : 0;
    m_blink   = 0;
    m_up      = 1'b1;
  endtask

  task automatic model_step();
    bit acc, tk;
    if (rst) begin
      model_reset();
      return;
    end
    acc   = cmd_valid && !m_pending;
    tk    = (m_cnt == P);
    m_cnt = tk ? 0 : m_cnt + 1;
    if (tk) begin
      if (m_pending) begin
        if ((m_fading || (FADE && m_pend != m_mode)) && m_duty != 0) begin
          m_fading = 1'b1;
          m_duty   = (m_duty > STP) ? m_duty - STP : 0;
        end else begin
          model_apply();
        end
      end else if (m_mode == 2) begin
        if (m_blink == BP - 1) begin
          m_blink = 0;
          m_duty  = (m_duty == 0) ? MAXD : 0;
        end else begin
          m_blink++;
        end
      end else if (m_mode == 3) begin
        if (m_up) begin
          if (m_duty == MAXD) m_up = 1'b0;
          else m_duty = (m_duty + STP > MAXD) ? MAXD : m_duty + STP;
        end else begin
          if (m_duty == 0) m_up = 1'b1;
          else m_duty = (m_duty > STP) ? m_duty - STP : 0;
        end
      end
    end
    if (acc) begin
      m_pending = 1'b1;
      m_pend    = int'(cmd_mode);
    end
  endtask

  // Check all outputs against the model, then advance one clock
  task automatic cyc();
    chk("led",       32'(led),       32'(m_cnt < m_duty));
    chk("tick",      32'(tick),      32'(m_cnt == P));
    chk("busy",      32'(busy),      32'(m_pending));
    chk("cmd_ready", 32'(cmd_ready), 32'(!m_pending));
    chk("mode_o",    32'(mode_o),    32'(m_mode));
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic period_count(output int n);
    n = 0;
    repeat (LEN) begin
      n += int'(led);
      cyc();
    end
  endtask

  task automatic send(input logic [1:0] md);
    int t = 0;
    while (!cmd_ready && t < 400) begin
      cyc();
      t++;
    end
    if (t >= 400) chk("send_timeout", 32'(0), 32'(1));
    cmd_valid = 1'b1;
    cmd_mode  = md;
    cyc();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_applied();
    int t = 0;
    while (busy && t < 400) begin
      cyc();
      t++;
    end
    if (t >= 400) chk("apply_timeout", 32'(0), 32'(1));
  endtask

  initial begin
    int n;
    int t;
    int exp_breathe[12] = '{0, 5, 10, 15, 20, 20, 15, 10, 5, 0, 0, 5};
    int exp_blink[8]    = '{20, 20, 0, 0, 20, 20, 0, 0};

    rst = 1'b1; cmd_valid = 1'b0; cmd_mode = 2'd0;
    @(posedge clk);
    #1;
    model_reset();
    cyc();
    rst = 1'b0;
    chk("rst_led",   32'(led),       32'(0));
    chk("rst_tick",  32'(tick),      32'(0));
    chk("rst_busy",  32'(busy),      32'(0));
    chk("rst_ready", 32'(cmd_ready), 32'(1));
    chk("rst_mode",  32'(mode_o),    32'(0));

    // Idle: ticks on the last cycle of every period
    for (int i = 0; i < 100; i++) begin
      chk("idle_tick_pos", 32'(tick), 32'((i % LEN) == LEN - 1));
      chk("idle_led",      32'(led),  32'(0));
      cyc();
    end

    // ON accepted at cycle 3, busy through cycle 19, applied at cycle 20
    repeat (3) cyc();
    chk("on_ready", 32'(cmd_ready), 32'(1));
    cmd_valid = 1'b1; cmd_mode = 2'd1;
    cyc();
    cmd_valid = 1'b0;
    for (int i = 4; i < LEN; i++) begin
      chk("on_busy", 32'(busy), 32'(1));
      cyc();
    end
    chk("on_mode", 32'(mode_o), 32'(1));
    period_count(n);
    chk("on_period", 32'(n), 32'(20));

    // BREATHE ramp
    send(2'd3);
    wait_applied();
    for (int k = 0; k < 12; k++) begin
      period_count(n);
      chk("breathe_period", 32'(n), 32'(exp_breathe[k]));
    end

    // BLINK
    send(2'd2);
    wait_applied();
    for (int k = 0; k < 8; k++) begin
      period_count(n);
      chk("blink_period", 32'(n), 32'(exp_blink[k]));
    end

    // Second command held valid while the first is pending
    cmd_valid = 1'b1; cmd_mode = 2'd1;
    cyc();
    cmd_mode = 2'd0;
    t = 0;
    while (busy && t < 400) begin
      chk("held_not_ready", 32'(cmd_ready), 32'(0));
      cyc();
      t++;
    end
    if (t >= 400) chk("held_timeout", 32'(0), 32'(1));
    chk("held_first_mode", 32'(mode_o), 32'(1));
    chk("held_ready", 32'(cmd_ready), 32'(1));
    cyc();
    cmd_valid = 1'b0;
    chk("held_second_busy", 32'(busy), 32'(1));
    t = 0;
    while (busy && t < 400) begin
      cyc();
      t++;
    end
`ifndef FADE_OUT_EN
    chk("held_second_latency", 32'(t), 32'(LEN - 1));
`endif
    chk("held_second_mode", 32'(mode_o), 32'(0));

    // Reset mid-period with BREATHE at duty 15
    send(2'd3);
    wait_applied();
    repeat (3 * LEN + 5) cyc();
    chk("pre_rst_led", 32'(led), 32'(1));
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("post_rst_led",   32'(led),       32'(0));
    chk("post_rst_tick",  32'(tick),      32'(0));
    chk("post_rst_busy",  32'(busy),      32'(0));
    chk("post_rst_ready", 32'(cmd_ready), 32'(1));
    chk("post_rst_mode",  32'(mode_o),    32'(0));
    repeat (LEN) cyc();

`ifdef FADE_OUT_EN
    // BREATHE at duty 15 fades to zero before ON takes effect
    send(2'd3);
    wait_applied();
    repeat (3 * LEN + 5) cyc();
    send(2'd1);
    repeat (LEN - 6) cyc();
    period_count(n);
    chk("fade_p1", 32'(n), 32'(10));
    period_count(n);
    chk("fade_p2", 32'(n), 32'(5));
    chk("fade_mode_held", 32'(mode_o), 32'(3));
    chk("fade_busy", 32'(busy), 32'(1));
    period_count(n);
    chk("fade_p3", 32'(n), 32'(0));
    chk("fade_mode_on", 32'(mode_o), 32'(1));
    period_count(n);
    chk("fade_p4", 32'(n), 32'(20));
`endif

    // Random commands and occasional resets
    repeat (2000) begin
      rst       = ($urandom_range(0, 149) == 0);
      cmd_valid = ($urandom_range(0, 3) == 0);
      cmd_mode  = 2'($urandom_range(0, 3));
      cyc();
    end
    rst = 1'b0;
    cmd_valid = 1'b0;
    repeat (2 * LEN) cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
